riscv_misalign_splitter: RTL and testbench

Successor to the combinational misalignment checker. This block sits between the execute/memory stage and the data-memory port. It detects misaligned loads and stores and, when SPLIT_EN=1, performs accesses that cross a word boundary as two aligned bus beats. It merges load data, sign- or zero-extends it, and stalls the pipeline until the access completes. With SPLIT_EN=0 it reproduces the legacy trap behaviour: any misaligned access raises an exception.

---
 rtl/riscv_misalign_splitter_pkg.sv | 25 ++
 rtl/riscv_misalign_splitter_if.sv | 55 +++++
 rtl/riscv_misalign_splitter_lane.sv | 58 +++++
 rtl/riscv_misalign_splitter.sv | 133 +++++++++++++
 tb/tb_riscv_misalign_splitter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_misalign_splitter_pkg.sv
// Shared encodings for the misaligned load/store splitter.
package riscv_misalign_splitter_pkg;

    // Access size encoding carried on the size field of a request.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Splitter sequencing: accept, first beat, optional second beat, respond.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/riscv_misalign_splitter_if.sv
// Pipeline-side request/response and data-memory bus of the splitter.
//
// Handshake: a request (req_valid plus its fields) is held stable while
// o_stall is high. A bus beat completes in a cycle where mem_req and mem_ack
// are both high; load data on mem_rdata is valid in that same cycle, and an
// ack while mem_req is low is ignored. resp_valid is a one-cycle completion
// pulse carrying rdata; exceptions are flagged in the request cycle itself.
interface riscv_misalign_splitter_if #(
    parameter int XLEN = 64
);
    import riscv_misalign_splitter_pkg::*;

    localparam int W = XLEN / 8;

    logic            i_riscv_msplit_req_valid;
    logic            i_riscv_msplit_is_store;
    logic [1:0]      i_riscv_msplit_size;
    logic            i_riscv_msplit_unsigned;
    logic [XLEN-1:0] i_riscv_msplit_addr;
    logic [XLEN-1:0] i_riscv_msplit_wdata;
    logic            o_riscv_msplit_stall;
    logic            o_riscv_msplit_resp_valid;
    logic [XLEN-1:0] o_riscv_msplit_rdata;
    logic            o_riscv_msplit_load_misaligned;
    logic            o_riscv_msplit_store_misaligned;
    logic            o_riscv_msplit_mem_req;
    logic            o_riscv_msplit_mem_we;
    logic [XLEN-1:0] o_riscv_msplit_mem_addr;
    logic [W-1:0]    o_riscv_msplit_mem_bmask;
    logic [XLEN-1:0] o_riscv_msplit_mem_wdata;
    logic            i_riscv_msplit_mem_ack;
    logic [XLEN-1:0] i_riscv_msplit_mem_rdata;
    state_e          o_riscv_msplit_dbg_state;

    modport master (
        output i_riscv_msplit_req_valid, i_riscv_msplit_is_store, i_riscv_msplit_size,
               i_riscv_msplit_unsigned, i_riscv_msplit_addr, i_riscv_msplit_wdata,
               i_riscv_msplit_mem_ack, i_riscv_msplit_mem_rdata,
        input  o_riscv_msplit_stall, o_riscv_msplit_resp_valid, o_riscv_msplit_rdata,
               o_riscv_msplit_load_misaligned, o_riscv_msplit_store_misaligned,
               o_riscv_msplit_mem_req, o_riscv_msplit_mem_we, o_riscv_msplit_mem_addr,
               o_riscv_msplit_mem_bmask, o_riscv_msplit_mem_wdata, o_riscv_msplit_dbg_state
    );

    modport slave (
        input  i_riscv_msplit_req_valid, i_riscv_msplit_is_store, i_riscv_msplit_size,
               i_riscv_msplit_unsigned, i_riscv_msplit_addr, i_riscv_msplit_wdata,
               i_riscv_msplit_mem_ack, i_riscv_msplit_mem_rdata,
        output o_riscv_msplit_stall, o_riscv_msplit_resp_valid, o_riscv_msplit_rdata,
               o_riscv_msplit_load_misaligned, o_riscv_msplit_store_misaligned,
               o_riscv_msplit_mem_req, o_riscv_msplit_mem_we, o_riscv_msplit_mem_addr,
               o_riscv_msplit_mem_bmask, o_riscv_msplit_mem_wdata, o_riscv_msplit_dbg_state
    );

endinterface

// File: rtl/riscv_misalign_splitter_lane.sv
// Byte-lane steering for one bus beat: byte enables, positioned store data,
// load-data merging and final sign/zero extension.
module riscv_misalign_splitter_lane
    import riscv_misalign_splitter_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [1:0]                size_i,
    input  logic                      beat2_i,
    input  logic                      is_store_i,
    input  logic                      is_unsigned_i,
    input  logic [XLEN-1:0]           wdata_i,
    input  logic [XLEN-1:0]           rdata_i,
    input  logic [XLEN-1:0]           merge_i,
    output logic [XLEN/8-1:0]         bmask_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic [XLEN-1:0]           merge_o,
    output logic [XLEN-1:0]           ext_o
);
    localparam int W    = XLEN / 8;
    localparam int W2   = 2 * W;
    localparam int OFFW = $clog2(W);
    localparam int SHW  = OFFW + 4;

    logic [W2-1:0]  nmask;
    logic [W2-1:0]  span;
    logic [SHW-1:0] sh_lo;
    logic [SHW-1:0] sh_hi;

    // The access occupies lanes off..off+n-1 of a two-word window; the low
    // word is beat 1 and the high word spills into beat 2.
    assign nmask = (W2'(1) << size_bytes(size_i)) - W2'(1);
    assign span  = nmask << off_i;
    assign sh_lo = SHW'(off_i) << 3;
    assign sh_hi = SHW'(XLEN) - sh_lo;

    assign bmask_o = beat2_i ? span[W2-1:W] : span[W-1:0];
    assign wdata_o = beat2_i ? (wdata_i >> sh_hi) : (wdata_i << sh_lo);
    // Beat 1 supplies the low-order result bytes, beat 2 the remainder.
    assign merge_o = beat2_i ? (merge_i | (rdata_i << sh_hi)) : (rdata_i >> sh_lo);

    // Keep only n result bytes, then sign- or zero-extend; stores return 0.
    always_comb begin
        ext_o = merge_i;
        if (is_store_i) begin
            ext_o = '0;
        end else begin
            case (size_i)
                SZ_B:    ext_o = is_unsigned_i ? XLEN'(merge_i[7:0])  : XLEN'($signed(merge_i[7:0]));
                SZ_H:    ext_o = is_unsigned_i ? XLEN'(merge_i[15:0]) : XLEN'($signed(merge_i[15:0]));
                SZ_W:    ext_o = is_unsigned_i ? XLEN'(merge_i[31:0]) : XLEN'($signed(merge_i[31:0]));
                default: ext_o = merge_i;
            endcase
        end
    end

endmodule

// File: rtl/riscv_misalign_splitter.sv
// Misaligned load/store handler between the memory stage and the data bus.
// Boundary-crossing accesses become two aligned beats when SPLIT_EN=1;
// with SPLIT_EN=0 every misaligned access is trapped instead.
module riscv_misalign_splitter
    import riscv_misalign_splitter_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit SPLIT_EN = 1'b1
) (
    input logic                      i_riscv_msplit_clk,
    input logic                      i_riscv_msplit_rstn,
    riscv_misalign_splitter_if.slave bus
);
    localparam int W    = XLEN / 8;
    localparam int OFFW = $clog2(W);

    state_e          state_q;
    logic            is_store_q;
    logic            unsigned_q;
    logic            cross_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] merge_q;

    logic [3:0]      req_n;
    logic [OFFW-1:0] req_off;
    logic [4:0]      req_end;
    logic            req_misaligned;
    logic            req_size_bad;
    logic            req_illegal;
    logic            req_cross;
    logic            idle_req;
    logic            req_accept;
    logic            in_beat;
    logic            beat2;
    logic [XLEN-1:0] aligned;
    logic [W-1:0]    lane_bmask;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_merge;
    logic [XLEN-1:0] lane_ext;

    // Request decode, only meaningful while IDLE.
    assign req_n          = size_bytes(bus.i_riscv_msplit_size);
    assign req_off        = bus.i_riscv_msplit_addr[OFFW-1:0];
    assign req_misaligned = |(bus.i_riscv_msplit_addr[2:0] & (req_n[2:0] - 3'd1));
    assign req_size_bad   = (XLEN == 32) && (bus.i_riscv_msplit_size == SZ_D);
    assign req_illegal    = req_size_bad || (!SPLIT_EN && req_misaligned);
    assign req_end        = 5'(req_off) + 5'(req_n);
    assign req_cross      = req_end > 5'(W);
    // Gated by reset so that outputs read zero while reset is held.
    assign idle_req       = i_riscv_msplit_rstn && (state_q == ST_IDLE) && bus.i_riscv_msplit_req_valid;
    assign req_accept     = idle_req && !req_illegal;

    assign in_beat = (state_q == ST_BEAT1) || (state_q == ST_BEAT2);
    assign beat2   = (state_q == ST_BEAT2);
    assign aligned = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

    riscv_misalign_splitter_lane #(.XLEN(XLEN)) u_lane (
        .off_i         (addr_q[OFFW-1:0]),
        .size_i        (size_q),
        .beat2_i       (beat2),
        .is_store_i    (is_store_q),
        .is_unsigned_i (unsigned_q),
        .wdata_i       (wdata_q),
        .rdata_i       (bus.i_riscv_msplit_mem_rdata),
        .merge_i       (merge_q),
        .bmask_o       (lane_bmask),
        .wdata_o       (lane_wdata),
        .merge_o       (lane_merge),
        .ext_o         (lane_ext)
    );

    // Sequencer: capture request, run one or two beats, pulse completion.
    always_ff @(posedge i_riscv_msplit_clk or negedge i_riscv_msplit_rstn) begin
        if (!i_riscv_msplit_rstn) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            cross_q    <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_accept) begin
                        is_store_q <= bus.i_riscv_msplit_is_store;
                        unsigned_q <= bus.i_riscv_msplit_unsigned;
                        size_q     <= bus.i_riscv_msplit_size;
                        addr_q     <= bus.i_riscv_msplit_addr;
                        wdata_q    <= bus.i_riscv_msplit_wdata;
                        cross_q    <= req_cross;
                        merge_q    <= '0;
                        state_q    <= ST_BEAT1;
                    end
                end
                ST_BEAT1: begin
                    if (bus.i_riscv_msplit_mem_ack) begin
                        merge_q <= lane_merge;
                        state_q <= cross_q ? ST_BEAT2 : ST_DONE;
                    end
                end
                ST_BEAT2: begin
                    if (bus.i_riscv_msplit_mem_ack) begin
                        merge_q <= lane_merge;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline-side outputs.
    assign bus.o_riscv_msplit_stall            = req_accept || in_beat;
    assign bus.o_riscv_msplit_load_misaligned  = idle_req && req_illegal && !bus.i_riscv_msplit_is_store;
    assign bus.o_riscv_msplit_store_misaligned = idle_req && req_illegal && bus.i_riscv_msplit_is_store;
    assign bus.o_riscv_msplit_resp_valid       = (state_q == ST_DONE);
    assign bus.o_riscv_msplit_rdata            = (state_q == ST_DONE) ? lane_ext : '0;
    assign bus.o_riscv_msplit_dbg_state        = state_q;

    // Bus outputs; the second beat address wraps naturally at 2^XLEN.
    assign bus.o_riscv_msplit_mem_req   = in_beat;
    assign bus.o_riscv_msplit_mem_we    = in_beat && is_store_q;
    assign bus.o_riscv_msplit_mem_addr  = in_beat ? (beat2 ? aligned + XLEN'(W) : aligned) : '0;
    assign bus.o_riscv_msplit_mem_bmask = in_beat ? lane_bmask : '0;
    assign bus.o_riscv_msplit_mem_wdata = (in_beat && is_store_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_riscv_misalign_splitter.sv
// Directed bench for the misaligned access splitter (split, trap and 32-bit variants).
module tb_riscv_misalign_splitter;
  import riscv_misalign_splitter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   last_acc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_misalign_splitter_if #(.XLEN(64)) bus ();
  riscv_misalign_splitter_if #(.XLEN(64)) bus_ns ();
  riscv_misalign_splitter_if #(.XLEN(32)) bus32 ();

  riscv_misalign_splitter #(.XLEN(64), .SPLIT_EN(1'b1)) dut (
    .i_riscv_msplit_clk(clk), .i_riscv_msplit_rstn(rst_n), .bus(bus));
  riscv_misalign_splitter #(.XLEN(64), .SPLIT_EN(1'b0)) dut_ns (
    .i_riscv_msplit_clk(clk), .i_riscv_msplit_rstn(rst_n), .bus(bus_ns));
  riscv_misalign_splitter #(.XLEN(32), .SPLIT_EN(1'b1)) dut32 (
    .i_riscv_msplit_clk(clk), .i_riscv_msplit_rstn(rst_n), .bus(bus32));

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] addr;
    logic [7:0]  bmask;
    logic        we;
    logic [63:0] wdata;
  } beat_t;
  typedef struct {
    logic [63:0] rdata;
    int          lat;
  } resp_t;

  beat_t      beat_q[$];
  resp_t      resp_q[$];
  logic [1:0] exc_ns_q[$];
  logic [1:0] exc32_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] lane_bits(input logic [7:0] bm);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{bm[i]}};
    return m;
  endfunction

  task automatic push_beat(input logic [63:0] a, input logic [7:0] bm, input logic we, input logic [63:0] wd);
    beat_t e;
    e.addr = a; e.bmask = bm; e.we = we; e.wdata = wd;
    beat_q.push_back(e);
  endtask

  task automatic push_resp(input logic [63:0] rd, input int lat);
    resp_t r;
    r.rdata = rd; r.lat = lat;
    resp_q.push_back(r);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.i_riscv_msplit_req_valid = 0; bus.i_riscv_msplit_is_store = 0; bus.i_riscv_msplit_size = 0;
    bus.i_riscv_msplit_unsigned = 0; bus.i_riscv_msplit_addr = 0; bus.i_riscv_msplit_wdata = 0;
    bus.i_riscv_msplit_mem_ack = 0; bus.i_riscv_msplit_mem_rdata = 0;
    bus_ns.i_riscv_msplit_req_valid = 0; bus_ns.i_riscv_msplit_is_store = 0; bus_ns.i_riscv_msplit_size = 0;
    bus_ns.i_riscv_msplit_unsigned = 0; bus_ns.i_riscv_msplit_addr = 0; bus_ns.i_riscv_msplit_wdata = 0;
    bus_ns.i_riscv_msplit_mem_ack = 0; bus_ns.i_riscv_msplit_mem_rdata = 0;
    bus32.i_riscv_msplit_req_valid = 0; bus32.i_riscv_msplit_is_store = 0; bus32.i_riscv_msplit_size = 0;
    bus32.i_riscv_msplit_unsigned = 0; bus32.i_riscv_msplit_addr = 0; bus32.i_riscv_msplit_wdata = 0;
    bus32.i_riscv_msplit_mem_ack = 0; bus32.i_riscv_msplit_mem_rdata = 0;
  endtask

  // One legal access on the split-enabled DUT; beats acked after d0/d1 wait cycles.
  task automatic access(input logic st, input logic [1:0] sz, input logic uns, input logic [63:0] a,
                        input logic [63:0] wd, input int nb, input int d0, input int d1,
                        input logic [63:0] r0, input logic [63:0] r1);
    @(posedge clk); #1;
    bus.i_riscv_msplit_req_valid = 1; bus.i_riscv_msplit_is_store = st; bus.i_riscv_msplit_size = sz;
    bus.i_riscv_msplit_unsigned = uns; bus.i_riscv_msplit_addr = a; bus.i_riscv_msplit_wdata = wd;
    last_acc = cyc;
    #1 check("accept_stall", 64'(bus.o_riscv_msplit_stall), 64'd1);
    @(posedge clk); #1;
    for (int b = 0; b < nb; b++) begin
      repeat ((b == 0) ? d0 : d1) begin @(posedge clk); #1; end
      bus.i_riscv_msplit_mem_ack = 1;
      bus.i_riscv_msplit_mem_rdata = (b == 0) ? r0 : r1;
      @(posedge clk); #1;
      bus.i_riscv_msplit_mem_ack = 0;
      bus.i_riscv_msplit_mem_rdata = 0;
    end
    bus.i_riscv_msplit_req_valid = 0;
    bus.i_riscv_msplit_wdata = 0;
  endtask

  // One-cycle request on the trap-mode DUT (wide32=0) or the 32-bit DUT (wide32=1).
  task automatic exc_req(input bit wide32, input logic st, input logic [1:0] sz, input logic [63:0] a);
    @(posedge clk); #1;
    if (!wide32) begin
      bus_ns.i_riscv_msplit_req_valid = 1; bus_ns.i_riscv_msplit_is_store = st;
      bus_ns.i_riscv_msplit_size = sz; bus_ns.i_riscv_msplit_addr = a;
    end else begin
      bus32.i_riscv_msplit_req_valid = 1; bus32.i_riscv_msplit_is_store = st;
      bus32.i_riscv_msplit_size = sz; bus32.i_riscv_msplit_addr = a[31:0];
    end
    @(posedge clk); #1;
    bus_ns.i_riscv_msplit_req_valid = 0;
    bus32.i_riscv_msplit_req_valid = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    beat_t      e;
    resp_t      r;
    logic [1:0] x;
    if (rst_n) begin
      if (bus.o_riscv_msplit_mem_req)
        check("beat_stall", 64'(bus.o_riscv_msplit_stall), 64'd1);
      if (bus.o_riscv_msplit_mem_req && bus.i_riscv_msplit_mem_ack) begin
        if (beat_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: addr 0x%0h with no beat expected", bus.o_riscv_msplit_mem_addr);
        end else begin
          e = beat_q.pop_front();
          check("beat_addr", bus.o_riscv_msplit_mem_addr, e.addr);
          check("beat_bmask", 64'(bus.o_riscv_msplit_mem_bmask), 64'(e.bmask));
          check("beat_we", 64'(bus.o_riscv_msplit_mem_we), 64'(e.we));
          if (e.we)
            check("beat_wdata", bus.o_riscv_msplit_mem_wdata & lane_bits(e.bmask), e.wdata);
        end
      end
      if (bus.o_riscv_msplit_resp_valid) begin
        if (resp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_resp: rdata 0x%0h with no response expected", bus.o_riscv_msplit_rdata);
        end else begin
          r = resp_q.pop_front();
          check("resp_rdata", bus.o_riscv_msplit_rdata, r.rdata);
          check("resp_latency", 64'(cyc - last_acc + 1), 64'(r.lat));
          check("resp_stall", 64'(bus.o_riscv_msplit_stall), 64'd0);
        end
      end
      if (bus.o_riscv_msplit_load_misaligned || bus.o_riscv_msplit_store_misaligned) begin
        n_tests++; n_fail++;
        $display("FAIL split_exception: exception raised on split-enabled DUT at cycle %0d", cyc);
      end
      if (bus_ns.o_riscv_msplit_load_misaligned || bus_ns.o_riscv_msplit_store_misaligned) begin
        x = exc_ns_q.size() > 0 ? exc_ns_q.pop_front() : 2'b00;
        check("trap_flags", 64'({bus_ns.o_riscv_msplit_load_misaligned, bus_ns.o_riscv_msplit_store_misaligned}), 64'(x));
        check("trap_mem_req", 64'(bus_ns.o_riscv_msplit_mem_req), 64'd0);
        check("trap_stall", 64'(bus_ns.o_riscv_msplit_stall), 64'd0);
      end
      if (bus32.o_riscv_msplit_load_misaligned || bus32.o_riscv_msplit_store_misaligned) begin
        x = exc32_q.size() > 0 ? exc32_q.pop_front() : 2'b00;
        check("x32_flags", 64'({bus32.o_riscv_msplit_load_misaligned, bus32.o_riscv_msplit_store_misaligned}), 64'(x));
        check("x32_mem_req", 64'(bus32.o_riscv_msplit_mem_req), 64'd0);
        check("x32_stall", 64'(bus32.o_riscv_msplit_stall), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 64'(bus.o_riscv_msplit_stall), 64'd0);
    check("rst_mem_req", 64'(bus.o_riscv_msplit_mem_req), 64'd0);
    check("rst_resp_valid", 64'(bus.o_riscv_msplit_resp_valid), 64'd0);
    check("rst_mem_addr", bus.o_riscv_msplit_mem_addr, 64'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_state", 64'(bus.o_riscv_msplit_dbg_state), 64'(ST_IDLE));
    check("post_rst_rdata", bus.o_riscv_msplit_rdata, 64'd0);

    // lw at 0x1004; lanes 0-3 of the ack data are outside the access.
    push_beat(64'h1000, 8'hF0, 1'b0, 64'h0);
    push_resp(64'hFFFF_FFFF_8000_0000, 3);
    access(1'b0, SZ_W, 1'b0, 64'h1004, 64'h0, 1, 0, 0, 64'h8000_0000_0000_0001, 64'h0);

    // ld at 0x1005 crossing into the next word.
    push_beat(64'h1000, 8'hE0, 1'b0, 64'h0);
    push_beat(64'h1008, 8'h1F, 1'b0, 64'h0);
    push_resp(64'hDDCC_BBAA_9988_7766, 4);
    access(1'b0, SZ_D, 1'b0, 64'h1005, 64'h0, 2, 0, 0, 64'h8877_6655_4433_2211, 64'h00FF_EEDD_CCBB_AA99);

    // sh at 0x1007 split across two beats; stores respond with zero.
    push_beat(64'h1000, 8'h80, 1'b1, 64'hEF00_0000_0000_0000);
    push_beat(64'h1008, 8'h01, 1'b1, 64'h0000_0000_0000_00BE);
    push_resp(64'h0, 4);
    access(1'b1, SZ_H, 1'b0, 64'h1007, 64'hBEEF, 2, 0, 0, 64'h0, 64'h0);

    // sb at 0x1003 with junk above the byte.
    push_beat(64'h1000, 8'h08, 1'b1, 64'h0000_0000_5500_0000);
    push_resp(64'h0, 3);
    access(1'b1, SZ_B, 1'b0, 64'h1003, 64'hFFFF_FFFF_FFFF_FF55, 1, 0, 0, 64'h0, 64'h0);

    // lh at 0x1003: misaligned but within one word, sign-extended.
    push_beat(64'h1000, 8'h18, 1'b0, 64'h0);
    push_resp(64'hFFFF_FFFF_FFFF_F1E2, 3);
    access(1'b0, SZ_H, 1'b0, 64'h1003, 64'h0, 1, 0, 0, 64'h0000_00F1_E200_0000, 64'h0);

    // lwu at 0x100E crossing, zero-extended; junk in unused beat-2 lanes.
    push_beat(64'h1008, 8'hC0, 1'b0, 64'h0);
    push_beat(64'h1010, 8'h03, 1'b0, 64'h0);
    push_resp(64'h0000_0000_90C3_A1B2, 4);
    access(1'b0, SZ_W, 1'b1, 64'h100E, 64'h0, 2, 0, 0, 64'hA1B2_0000_0000_0000, 64'h1111_1111_1111_90C3);

    // ld at the top of the address space wraps; first ack delayed 3 cycles.
    push_beat(64'hFFFF_FFFF_FFFF_FFF8, 8'hF0, 1'b0, 64'h0);
    push_beat(64'h0, 8'h0F, 1'b0, 64'h0);
    push_resp(64'h8877_6655_4433_2211, 7);
    access(1'b0, SZ_D, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 2, 3, 0, 64'h4433_2211_DEAD_BEEF, 64'hCAFE_F00D_8877_6655);

    // Trap mode: lhu at 0x1001 and sw at 0x1002; 32-bit DUT: any dword access.
    exc_ns_q.push_back(2'b10);
    exc_req(1'b0, 1'b0, SZ_H, 64'h1001);
    exc_ns_q.push_back(2'b01);
    exc_req(1'b0, 1'b1, SZ_W, 64'h1002);
    exc32_q.push_back(2'b10);
    exc_req(1'b1, 1'b0, SZ_D, 64'h1000);
    exc32_q.push_back(2'b01);
    exc_req(1'b1, 1'b1, SZ_D, 64'h2000);

    // Reset during the second beat of ld at 0x3006 aborts it.
    push_beat(64'h3000, 8'hC0, 1'b0, 64'h0);
    @(posedge clk); #1;
    bus.i_riscv_msplit_req_valid = 1; bus.i_riscv_msplit_is_store = 0;
    bus.i_riscv_msplit_size = SZ_D; bus.i_riscv_msplit_unsigned = 0; bus.i_riscv_msplit_addr = 64'h3006;
    @(posedge clk); #1;
    bus.i_riscv_msplit_mem_ack = 1; bus.i_riscv_msplit_mem_rdata = 64'h1234_0000_0000_0000;
    @(posedge clk); #1;
    bus.i_riscv_msplit_mem_ack = 0; bus.i_riscv_msplit_mem_rdata = 0;
    check("beat2_state", 64'(bus.o_riscv_msplit_dbg_state), 64'(ST_BEAT2));
    rst_n = 0;
    #1;
    check("abort_stall", 64'(bus.o_riscv_msplit_stall), 64'd0);
    check("abort_mem_req", 64'(bus.o_riscv_msplit_mem_req), 64'd0);
    check("abort_mem_addr", bus.o_riscv_msplit_mem_addr, 64'd0);
    check("abort_bmask", 64'(bus.o_riscv_msplit_mem_bmask), 64'd0);
    check("abort_resp_valid", 64'(bus.o_riscv_msplit_resp_valid), 64'd0);
    bus.i_riscv_msplit_req_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;

    // lbu at 0x2003 after the abort.
    push_beat(64'h2000, 8'h08, 1'b0, 64'h0);
    push_resp(64'h9A, 3);
    access(1'b0, SZ_B, 1'b1, 64'h2003, 64'h0, 1, 0, 0, 64'h0000_0000_9A00_0000, 64'h0);

    repeat (3) @(posedge clk);
    #1;
    check("beats_left", 64'(beat_q.size()), 64'd0);
    check("resps_left", 64'(resp_q.size()), 64'd0);
    check("trap_left", 64'(exc_ns_q.size()), 64'd0);
    check("x32_left", 64'(exc32_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
